// File: rtl/game_sequencer.sv
// Game-flow controller: IDLE/RUN/DYING/OVER sequencing, BCD score and high score,
// speed level, and the freeze/spawn/start/over controls for the datapath blocks.
`timescale 1ns/1ps
module game_sequencer #(
  parameter int SCORE_DIV     = 6,
  parameter int DEATH_TICKS   = 30,
  parameter int LOCKOUT_TICKS = 30,
  parameter int MAX_SPEED     = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_game_tick,
  input  logic        i_button_up,
  input  logic        i_collision,
  output logic [1:0]  o_state,
  output logic [15:0] o_score,
  output logic [15:0] o_high_score,
  output logic [2:0]  o_speed,
  output logic        o_spawn_en,
  output logic        o_freeze,
  output logic        o_start_pulse,
  output logic        o_over_pulse
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DYING = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [5:0] SCORE_LAST = 6'(SCORE_DIV - 1);
  localparam logic [5:0] DEATH_LAST = 6'(DEATH_TICKS - 1);
  localparam logic [5:0] LOCK_DONE  = 6'(LOCKOUT_TICKS);
  localparam logic [2:0] SPEED_MAX  = 3'(MAX_SPEED);

  logic [1:0]  state_reg, state_next;
  logic [15:0] score_reg, score_next;
  logic [15:0] high_reg, high_next;
  logic [2:0]  speed_reg, speed_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic        btn_prev_reg;
  logic        start_reg, start_next;
  logic        over_reg, over_next;
  logic        freeze_reg, spawn_reg;

  logic        press;
  logic [15:0] score_inc;
  logic [4:0]  carry;

  assign press = i_button_up & ~btn_prev_reg;

  // Ripple BCD incrementer; carry[2] marks a x00 rollover, carry[4] means the score is 9999.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] digit;
      assign digit = score_reg[gi*4 +: 4];
      assign score_inc[gi*4 +: 4] = carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
      assign carry[gi+1] = carry[gi] & (digit == 4'd9);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    score_next = score_reg;
    high_next  = high_reg;
    speed_next = speed_reg;
    cnt_next   = cnt_reg;
    start_next = 1'b0;
    over_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (press) begin
          state_next = ST_RUN;
          score_next = 16'h0000;
          speed_next = 3'd0;
          cnt_next   = 6'd0;
          start_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_collision) begin
          state_next = ST_DYING;
          cnt_next   = 6'd0;
        end else if (i_game_tick) begin
          if (cnt_reg >= SCORE_LAST) begin
            cnt_next = 6'd0;
            if (!carry[4]) begin
              score_next = score_inc;
              if (carry[2] && (speed_reg < SPEED_MAX))
                speed_next = speed_reg + 3'd1;
            end
          end else begin
            cnt_next = cnt_reg + 6'd1;
          end
        end
      end
      ST_DYING: begin
        if (i_game_tick) begin
          if (cnt_reg >= DEATH_LAST) begin
            state_next = ST_OVER;
            cnt_next   = 6'd0;
            over_next  = 1'b1;
            if (score_reg > high_reg)
              high_next = score_reg;
          end else begin
            cnt_next = cnt_reg + 6'd1;
          end
        end
      end
      default: begin
        // OVER: the counter doubles as the restart lockout timer.
        if (press && (cnt_reg >= LOCK_DONE)) begin
          state_next = ST_RUN;
          score_next = 16'h0000;
          speed_next = 3'd0;
          cnt_next   = 6'd0;
          start_next = 1'b1;
        end else if (i_game_tick && (cnt_reg < LOCK_DONE)) begin
          cnt_next = cnt_reg + 6'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      score_reg    <= 16'h0000;
      high_reg     <= 16'h0000;
      speed_reg    <= 3'd0;
      cnt_reg      <= 6'd0;
      btn_prev_reg <= 1'b0;
      start_reg    <= 1'b0;
      over_reg     <= 1'b0;
      freeze_reg   <= 1'b1;
      spawn_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      score_reg    <= score_next;
      high_reg     <= high_next;
      speed_reg    <= speed_next;
      cnt_reg      <= cnt_next;
      btn_prev_reg <= i_button_up;
      start_reg    <= start_next;
      over_reg     <= over_next;
      freeze_reg   <= (state_next != ST_RUN);
      spawn_reg    <= (state_next == ST_RUN);
    end
  end

  assign o_state       = state_reg;
  assign o_score       = score_reg;
  assign o_high_score  = high_reg;
  assign o_speed       = speed_reg;
  assign o_spawn_en    = spawn_reg;
  assign o_freeze      = freeze_reg;
  assign o_start_pulse = start_reg;
  assign o_over_pulse  = over_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a short vector table for reset/start/ignore
// behaviour, then hand-written sequences for scoring, lockout and high-score corners.
`timescale 1ns/1ps
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        btn = 1'b0;
  logic        coll = 1'b0;
  logic [1:0]  st;
  logic [15:0] score, high;
  logic [2:0]  speed;
  logic        spawn, freeze, start_p, over_p;

  int checks = 0;
  int errors = 0;

  game_sequencer dut (
    .clk(clk), .rst(rst), .i_game_tick(tick), .i_button_up(btn), .i_collision(coll),
    .o_state(st), .o_score(score), .o_high_score(high), .o_speed(speed),
    .o_spawn_en(spawn), .o_freeze(freeze), .o_start_pulse(start_p), .o_over_pulse(over_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, tick, btn, coll;
    logic [1:0]  st;
    logic [15:0] score, high;
    logic [2:0]  speed;
    logic        spawn, freeze, start_p, over_p;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          rst tk bt co  st    score     high      spd sp fz sta ovr
    vecs[0]  = '{1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 3'd0, 0, 1, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 3'd0, 0, 1, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 2'd0, 16'h0000, 16'h0000, 3'd0, 0, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 2'd0, 16'h0000, 16'h0000, 3'd0, 0, 1, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 2'd1, 16'h0000, 16'h0000, 3'd0, 1, 0, 1, 0};
    vecs[5]  = '{0, 0, 1, 0, 2'd1, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 2'd1, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 2'd1, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 2'd1, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 2'd1, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 2'd1, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 2'd1, 16'h0000, 16'h0000, 3'd0, 1, 0, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 2'd1, 16'h0001, 16'h0000, 3'd0, 1, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 1, 2'd2, 16'h0001, 16'h0000, 3'd0, 0, 1, 0, 0};
    vecs[14] = '{0, 0, 1, 0, 2'd2, 16'h0001, 16'h0000, 3'd0, 0, 1, 0, 0};
    vecs[15] = '{0, 1, 0, 1, 2'd2, 16'h0001, 16'h0000, 3'd0, 0, 1, 0, 0};
    vecs[16] = '{0, 0, 0, 0, 2'd2, 16'h0001, 16'h0000, 3'd0, 0, 1, 0, 0};

    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst; tick = vecs[i].tick; btn = vecs[i].btn; coll = vecs[i].coll;
      step();
      chk($sformatf("vec%0d state", i), 16'(st), 16'(vecs[i].st));
      chk($sformatf("vec%0d score", i), score, vecs[i].score);
      chk($sformatf("vec%0d high", i), high, vecs[i].high);
      chk($sformatf("vec%0d speed", i), 16'(speed), 16'(vecs[i].speed));
      chk($sformatf("vec%0d spawn", i), 16'(spawn), 16'(vecs[i].spawn));
      chk($sformatf("vec%0d freeze", i), 16'(freeze), 16'(vecs[i].freeze));
      chk($sformatf("vec%0d start", i), 16'(start_p), 16'(vecs[i].start_p));
      chk($sformatf("vec%0d over", i), 16'(over_p), 16'(vecs[i].over_p));
      $display("vec %0d: state=%0d score=%h high=%h speed=%0d", i, st, score, high, speed);
    end
    tick = 1'b0; btn = 1'b0; coll = 1'b0;

    // Game 1: collision on the same clk as a score increment at 0041.
    rst = 1'b1; repeat (2) step(); rst = 1'b0;
    btn = 1'b1; step(); btn = 1'b0;
    chk("g1 start state", 16'(st), 16'd1);
    step();
    run_ticks(246);
    chk("g1 score 0041", score, 16'h0041);
    run_ticks(5);
    tick = 1'b1; coll = 1'b1; step(); tick = 1'b0; coll = 1'b0;
    chk("g1 coll state", 16'(st), 16'd2);
    chk("g1 coll score", score, 16'h0041);
    chk("g1 dying freeze", 16'(freeze), 16'd1);
    run_ticks(29);
    chk("g1 dying 29", 16'(st), 16'd2);
    run_ticks(1);
    chk("g1 over state", 16'(st), 16'd3);
    chk("g1 over pulse", 16'(over_p), 16'd1);
    chk("g1 high", high, 16'h0041);
    step();
    chk("g1 over pulse end", 16'(over_p), 16'd0);
    coll = 1'b1; step(); coll = 1'b0;
    chk("g1 over coll state", 16'(st), 16'd3);
    chk("g1 over coll score", score, 16'h0041);
    $display("game1: state=%0d score=%h high=%h", st, score, high);

    // Lockout: press at tick 10 is ignored, and holding it past tick 30 does not retrigger.
    run_ticks(10);
    btn = 1'b1; step();
    chk("lockout press", 16'(st), 16'd3);
    run_ticks(20);
    chk("held past lockout", 16'(st), 16'd3);
    btn = 1'b0; step();
    btn = 1'b1; step();
    chk("restart state", 16'(st), 16'd1);
    chk("restart pulse", 16'(start_p), 16'd1);
    chk("restart score", score, 16'h0000);
    chk("restart speed", 16'(speed), 16'd0);
    chk("restart high", high, 16'h0041);
    btn = 1'b0; step();
    chk("restart pulse end", 16'(start_p), 16'd0);
    $display("restart: state=%0d score=%h high=%h", st, score, high);

    // Game 2 ends at 0020; high score must not drop.
    run_ticks(120);
    chk("g2 score", score, 16'h0020);
    coll = 1'b1; step(); coll = 1'b0;
    run_ticks(30);
    chk("g2 over state", 16'(st), 16'd3);
    chk("g2 high kept", high, 16'h0041);
    chk("g2 score held", score, 16'h0020);
    $display("game2: state=%0d score=%h high=%h", st, score, high);

    // Game 3: speed ramp and 9999 saturation.
    run_ticks(30);
    btn = 1'b1; step(); btn = 1'b0;
    chk("g3 start state", 16'(st), 16'd1);
    run_ticks(600);
    chk("g3 score 0100", score, 16'h0100);
    chk("g3 speed 1", 16'(speed), 16'd1);
    run_ticks(4194);
    chk("g3 score 0799", score, 16'h0799);
    chk("g3 speed 7", 16'(speed), 16'd7);
    run_ticks(6);
    chk("g3 score 0800", score, 16'h0800);
    chk("g3 speed sat", 16'(speed), 16'd7);
    run_ticks(55194);
    chk("g3 score 9999", score, 16'h9999);
    run_ticks(12);
    chk("g3 score sat", score, 16'h9999);
    chk("g3 state run", 16'(st), 16'd1);
    $display("game3: state=%0d score=%h speed=%0d", st, score, speed);

    // Reset while DYING clears everything including the high score.
    coll = 1'b1; step(); coll = 1'b0;
    chk("g3 dying", 16'(st), 16'd2);
    run_ticks(5);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid rst state", 16'(st), 16'd0);
    chk("mid rst score", score, 16'h0000);
    chk("mid rst high", high, 16'h0000);
    chk("mid rst speed", 16'(speed), 16'd0);
    chk("mid rst freeze", 16'(freeze), 16'd1);
    $display("mid reset: state=%0d score=%h high=%h", st, score, high);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Central game-flow controller between the debounced buttons, collision detector, obstacle generator and score renderer.
- Sequences the game through idle / run / dying / over.
- Keeps a 4-digit BCD score and a high score, and derives a speed level for the obstacle scroller.
- Emits freeze, spawn-enable and start/over pulses so the datapath blocks are started, stopped and cleared from one place.

Parameters:
SCORE_DIV, 6, game ticks per score increment while running (range 1-63)
DEATH_TICKS, 30, game ticks spent in DYING before OVER (range 1-63)
LOCKOUT_TICKS, 30, game ticks after entering OVER during which restart presses are ignored (range 0-63)
MAX_SPEED, 7, saturation value of o_speed (range 0-7)

Ports:
clk  input  1  system clock (pixel clock domain)
rst  input  1  synchronous reset, active-high
i_game_tick  input  1  one-clk pulse at 60 Hz frame rate
i_button_up  input  1  debounced jump/start button, level
i_collision  input  1  collision flag from graphics, sampled on clk
o_state  output  2  0=IDLE 1=RUN 2=DYING 3=OVER
o_score  output  16  BCD score {thousands,hundreds,tens,units}
o_high_score  output  16  BCD best score since reset
o_speed  output  3  scroll speed level
o_spawn_en  output  1  obstacle generation enable
o_freeze  output  1  halt scrolling/animation
o_start_pulse  output  1  one-clk pulse on entry to RUN
o_over_pulse  output  1  one-clk pulse on entry to OVER

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state updates on rising clk.
- Reset values: o_state=IDLE, o_score=0, o_high_score=0, o_speed=0, o_spawn_en=0, o_freeze=1, both pulses 0, all counters 0.
- Reset asserted mid-game returns to these values on the next edge; no partial state survives.
- Button edge: internal register of i_button_up; press = i_button_up & ~prev. Evaluated every clk, not only on ticks.
- IDLE:
  - o_freeze=1, o_spawn_en=0.
  - On press: go to RUN next clk; clear score, speed and tick counters; assert o_start_pulse for that one clk (registered, coincident with o_state=RUN).
- RUN:
  - o_freeze=0, o_spawn_en=1.
  - Tick counter increments on i_game_tick. When it reaches SCORE_DIV-1 and a tick arrives, it wraps to 0 and the score increments by 1 in BCD.
  - Each digit wraps 9->0 with carry. Score saturates at 9999 and further increments are dropped.
  - When an increment makes tens and units both 0 (every 100 points), o_speed increments, saturating at MAX_SPEED.
  - i_collision=1 on any clk -> DYING next clk; tick counter cleared.
  - Collision and score increment on the same clk: collision wins, score unchanged.
  - Presses are ignored.
- DYING:
  - o_freeze=1, o_spawn_en=0; score held.
  - Counts i_game_tick. On the DEATH_TICKS-th tick -> OVER.
  - On that transition, o_high_score <= o_score if o_score > o_high_score (unsigned compare of BCD word is valid). o_over_pulse is asserted for one clk coincident with o_state=OVER.
  - Collision and presses are ignored.
- OVER:
  - o_freeze=1, o_spawn_en=0; score and speed held for display.
  - Lockout counter counts ticks up to LOCKOUT_TICKS. Presses are ignored until the count is reached; with LOCKOUT_TICKS=0, presses are accepted immediately.
  - Accepted press -> RUN with the same clears and o_start_pulse as from IDLE.
- i_collision is ignored in every state except RUN.
- A press held across a state change does not retrigger; a new rising edge is required.
- Latency: every transition is exactly 1 clk after the causing event. Outputs are registered (no combinational path from inputs to outputs).

Test Plan:
- Reset/start: assert rst 3 clks; check all reset values. Pulse i_button_up -> next clk o_state=1, o_start_pulse=1 for exactly 1 clk, o_freeze=0, o_spawn_en=1.
- Scoring: in RUN apply 600 ticks with SCORE_DIV=6 -> o_score=16'h0100, o_speed=1. Continue to score 0799 -> o_speed=7. At 0800 -> o_speed stays 7.
- Saturation: preload via 59994 ticks to 9999, apply 12 more ticks -> o_score stays 16'h9999, no wrap to 0000.
- Collision priority: assert i_collision on the same clk as the 6th tick at score 0041 -> o_state=2 next clk, o_score=0041. After 30 ticks -> o_state=3, o_over_pulse single clk, o_high_score=0041.
- Lockout/restart: in OVER, press at tick 10 -> remains OVER. Press after tick 30 -> RUN, o_score=0, o_speed=0, o_high_score still 0041. Second game ending at 0020 -> o_high_score stays 0041.
- Ignored inputs/reset mid-game: i_collision in IDLE/DYING/OVER causes no change. Held button across the restart does not retrigger. rst asserted in DYING -> IDLE with o_high_score=0 next clk.
